tl_inflight_monitor: RTL and testbench
======================================

// Module: tl_inflight_monitor
// PURPOSE
//  Parametrised TileLink-UL/UH protocol monitor for one A/D link. Tracks outstanding requests per source ID,
//  burst beats and handshake stability, and flags protocol errors. Passive, outputs-only error reporting.
//  Bound beside a TL edge in testbench and FPGA-debug builds; never drives the link.
// PARAMETERS
//  SOURCE_BITS   4     source ID width; tracks 2**SOURCE_BITS sources
//  ADDR_BITS     32    A-channel address width
//  BEAT_BYTES    4     data bus bytes per beat (power of 2); mask width = BEAT_BYTES
//  SIZE_BITS     3     log2(transfer bytes) field width
//  TIMEOUT       1024  cycles with >=1 request outstanding and no D fire before timeout error (>=2)
// PORTS
//  clock          in   1             sole clock, rising edge
//  reset_n        in   1             synchronous reset, active-low
//  a_valid/a_ready in  1/1           A handshake; a_fire = a_valid & a_ready
//  a_opcode       in   3             0 PutFull,1 PutPartial,2 Arith,3 Logical,4 Get,5 Hint; 6-7 illegal
//  a_size         in   SIZE_BITS     log2 bytes
//  a_source       in   SOURCE_BITS   requester ID
//  a_address      in   ADDR_BITS     byte address
//  d_valid/d_ready in  1/1           D handshake; d_fire = d_valid & d_ready
//  d_opcode       in   3             0 AccessAck,1 AccessAckData,2 HintAck
//  d_size         in   SIZE_BITS     must echo request size
//  d_source       in   SOURCE_BITS   must match an outstanding source
//  err_valid      out  1             sticky; 1 after first error
//  err_code       out  4             code of first error (table below)
//  err_source     out  SOURCE_BITS   source ID involved in first error
//  err_count      out  8             total error events, saturates at 255
//  inflight_cnt   out  SOURCE_BITS+1 number of outstanding sources
// BEHAVIOUR
//  Reset: all outputs 0; inflight bitmap, per-source {opcode,size} table, beat counters, watchdog, stall regs cleared.
//  Beats: beats(size) = size>log2(BEAT_BYTES) ? 2**(size-log2(BEAT_BYTES)) : 1.
//   A multi-beat for opcodes 0-3; D multi-beat only for AccessAckData.
//  A first beat (A beat counter==0) on a_fire: sets inflight[a_source], stores {opcode,size}.
//  D last beat on d_fire clears inflight[d_source].
//   Same-cycle D-last and A-first on same source is legal: clear then set; bit ends 1.
//  Burst tracking: first beat latches opcode/size/source/address; counters wrap to 0 on last beat.
//  Stall tracking: if valid & !ready at cycle N, channel must present valid=1 with identical fields at N+1.
//  Watchdog: increments while inflight_cnt!=0 and !d_fire; clears on d_fire or inflight_cnt==0.
//   Reaching TIMEOUT-1 raises code 9 once, then clears.
//  Error codes (checked every cycle; several may fire together):
//   1 A illegal opcode (6,7)           2 A address not aligned to 2**a_size
//   3 A first beat, source already inflight (not cleared same cycle)
//   4 A mid-burst field change         5 D source not inflight
//   6 D opcode mismatch: Put*->AccessAck, Arith/Logical/Get->AccessAckData, Hint->HintAck
//   7 D size != stored size            8 D mid-burst field change
//   9 watchdog timeout                 10 A or D valid dropped / fields changed while stalled
//  Simultaneous errors: lowest code captured in err_code; err_count +1 per cycle with any error.
//  err_code/err_source written only while err_valid==0; later errors only count.
//  Erroneous beats still update tracking: code 5 clears nothing; code 3 overwrites table.
//  Outputs are registered: error visible the cycle after the offending edge.
//  reset_n low mid-burst or mid-stall: all state discarded next edge; no error reported.
// TESTING
//  Get src3 size2, D AccessAckData src3 size2 3 cycles later -> inflight_cnt 1 then 0, err_valid stays 0.
//  PutFull size4 (4 beats, BEAT_BYTES=4) src1, AccessAck src1 -> no error.
//   Repeat with size change on beat 2 -> err_code 4, err_source 1.
//  Get src5 twice without response -> err_code 3, err_source 5, err_count 1.
//   Same-cycle D-last src5 + A-first src5 -> no error.
//  Get src2, D AccessAck src2 -> err_code 6. D src7 never requested -> err_count increments, err_code stays 6.
//  A valid=1 ready=0, next cycle valid=0 -> err_code 10. Separately, Get src0, no D for TIMEOUT cycles -> err_code 9.
//  PutFull addr 0x1002 size2 plus opcode 7 same cycle -> err_code 1 (priority), err_count 1.
//   Assert reset_n=0 -> all outputs 0 next cycle.

Source files
------------

// File: rtl/tl_inflight_monitor.sv
// Passive TileLink-UL/UH A/D link monitor: per-source outstanding tracking, burst beat
// counting, stall stability and watchdog checks, with sticky first-error capture.
module tl_inflight_monitor #(
  parameter int SOURCE_BITS = 4,
  parameter int ADDR_BITS   = 32,
  parameter int BEAT_BYTES  = 4,
  parameter int SIZE_BITS   = 3,
  parameter int TIMEOUT     = 1024
) (
  input  logic                   clock,
  input  logic                   reset_n,
  input  logic                   a_valid,
  input  logic                   a_ready,
  input  logic [2:0]             a_opcode,
  input  logic [SIZE_BITS-1:0]   a_size,
  input  logic [SOURCE_BITS-1:0] a_source,
  input  logic [ADDR_BITS-1:0]   a_address,
  input  logic                   d_valid,
  input  logic                   d_ready,
  input  logic [2:0]             d_opcode,
  input  logic [SIZE_BITS-1:0]   d_size,
  input  logic [SOURCE_BITS-1:0] d_source,
  output logic                   err_valid,
  output logic [3:0]             err_code,
  output logic [SOURCE_BITS-1:0] err_source,
  output logic [7:0]             err_count,
  output logic [SOURCE_BITS:0]   inflight_cnt
);

  localparam int NSRC   = 2**SOURCE_BITS;
  localparam int LOG_BB = $clog2(BEAT_BYTES);
  localparam int CNT_W  = 2**SIZE_BITS;
  localparam int WD_W   = $clog2(TIMEOUT) + 1;
  localparam logic [SIZE_BITS-1:0] LOG_BB_S = SIZE_BITS'(LOG_BB);

  // Number of beats minus one for a burst of 2**size bytes.
  function automatic logic [CNT_W-1:0] beats_m1(input logic [SIZE_BITS-1:0] size);
    if (size > LOG_BB_S) return (CNT_W'(1) << (size - LOG_BB_S)) - CNT_W'(1);
    return '0;
  endfunction

  logic a_fire, d_fire;
  assign a_fire = a_valid & a_ready;
  assign d_fire = d_valid & d_ready;

  // A-channel burst state
  logic [CNT_W-1:0]       a_cnt_reg;
  logic [2:0]             a_op_reg;
  logic [SIZE_BITS-1:0]   a_size_reg;
  logic [SOURCE_BITS-1:0] a_src_reg;
  logic [ADDR_BITS-1:0]   a_addr_reg;
  logic                   a_first, a_last, a_set;
  logic [2:0]             a_op_eff;
  logic [SIZE_BITS-1:0]   a_size_eff;
  logic [CNT_W-1:0]       a_len_m1;

  assign a_first    = (a_cnt_reg == '0);
  assign a_op_eff   = a_first ? a_opcode : a_op_reg;
  assign a_size_eff = a_first ? a_size : a_size_reg;
  assign a_len_m1   = (a_op_eff <= 3'd3) ? beats_m1(a_size_eff) : '0;
  assign a_last     = (a_cnt_reg == a_len_m1);
  assign a_set      = a_fire & a_first;

  // D-channel burst state
  logic [CNT_W-1:0]       d_cnt_reg;
  logic [2:0]             d_op_reg;
  logic [SIZE_BITS-1:0]   d_size_reg;
  logic [SOURCE_BITS-1:0] d_src_reg;
  logic                   d_first, d_last, d_set, d_clr;
  logic [2:0]             d_op_eff;
  logic [SIZE_BITS-1:0]   d_size_eff;
  logic [SOURCE_BITS-1:0] d_src_eff;
  logic [CNT_W-1:0]       d_len_m1;

  assign d_first    = (d_cnt_reg == '0);
  assign d_op_eff   = d_first ? d_opcode : d_op_reg;
  assign d_size_eff = d_first ? d_size : d_size_reg;
  assign d_src_eff  = d_first ? d_source : d_src_reg;
  assign d_len_m1   = (d_op_eff == 3'd1) ? beats_m1(d_size_eff) : '0;
  assign d_last     = (d_cnt_reg == d_len_m1);
  assign d_set      = d_fire & d_first;
  assign d_clr      = d_fire & d_last;

  // Per-source inflight bit and {opcode,size} table
  logic [NSRC-1:0]      inflight_vec, inflight_next;
  logic [2:0]           tbl_op   [NSRC];
  logic [SIZE_BITS-1:0] tbl_size [NSRC];

  generate
    for (genvar gi = 0; gi < NSRC; gi++) begin : g_src
      logic                 busy_reg;
      logic [2:0]           op_reg;
      logic [SIZE_BITS-1:0] size_reg;
      logic                 set_hit, clr_hit;

      assign set_hit = a_set && (a_source == SOURCE_BITS'(gi));
      assign clr_hit = d_clr && (d_src_eff == SOURCE_BITS'(gi));
      // Clear before set, so a same-cycle D-last/A-first on one source leaves it busy.
      assign inflight_next[gi] = set_hit | (busy_reg & ~clr_hit);
      assign inflight_vec[gi]  = busy_reg;
      assign tbl_op[gi]        = op_reg;
      assign tbl_size[gi]      = size_reg;

      always_ff @(posedge clock) begin
        if (!reset_n) begin
          busy_reg <= 1'b0;
          op_reg   <= '0;
          size_reg <= '0;
        end else begin
          busy_reg <= inflight_next[gi];
          if (set_hit) begin
            op_reg   <= a_opcode;
            size_reg <= a_size;
          end
        end
      end
    end
  endgenerate

  // Stall hold registers: fields seen while valid & !ready
  logic                   a_stall_reg, d_stall_reg;
  logic [2:0]             a_hold_op_reg, d_hold_op_reg;
  logic [SIZE_BITS-1:0]   a_hold_size_reg, d_hold_size_reg;
  logic [SOURCE_BITS-1:0] a_hold_src_reg, d_hold_src_reg;
  logic [ADDR_BITS-1:0]   a_hold_addr_reg;
  logic                   a_stall_err, d_stall_err;

  assign a_stall_err = a_stall_reg & (!a_valid || a_opcode != a_hold_op_reg ||
                       a_size != a_hold_size_reg || a_source != a_hold_src_reg ||
                       a_address != a_hold_addr_reg);
  assign d_stall_err = d_stall_reg & (!d_valid || d_opcode != d_hold_op_reg ||
                       d_size != d_hold_size_reg || d_source != d_hold_src_reg);

  // Watchdog
  logic [WD_W-1:0] wd_reg, wd_next;
  logic            wd_run, wd_hit;
  assign wd_run  = (inflight_cnt != '0) && !d_fire;
  assign wd_hit  = wd_run && (wd_reg == WD_W'(TIMEOUT - 2));
  assign wd_next = (!wd_run || wd_hit) ? '0 : wd_reg + WD_W'(1);

  // Error detection: err_vec[i] is code i+1
  logic [9:0]             err_vec;
  logic [SOURCE_BITS-1:0] code_src [10];
  logic [ADDR_BITS-1:0]   align_mask;
  logic [1:0]             exp_dop;
  logic                   exp_ok, d_known;
  logic [SOURCE_BITS-1:0] wd_src;

  assign align_mask = (ADDR_BITS'(1) << a_size) - ADDR_BITS'(1);
  assign d_known    = inflight_vec[d_source];

  always_comb begin
    exp_ok  = 1'b1;
    exp_dop = 2'd0;
    case (tbl_op[d_source])
      3'd0, 3'd1:       exp_dop = 2'd0;
      3'd2, 3'd3, 3'd4: exp_dop = 2'd1;
      3'd5:             exp_dop = 2'd2;
      default:          exp_ok  = 1'b0;
    endcase
  end

  always_comb begin
    wd_src = '0;
    for (int i = NSRC - 1; i >= 0; i--) begin
      if (inflight_vec[i]) wd_src = SOURCE_BITS'(i);
    end
  end

  always_comb begin
    err_vec    = '0;
    err_vec[0] = a_fire && (a_opcode > 3'd5);
    err_vec[1] = a_set && ((a_address & align_mask) != '0);
    err_vec[2] = a_set && inflight_vec[a_source] && !(d_clr && d_src_eff == a_source);
    err_vec[3] = a_fire && !a_first && (a_opcode != a_op_reg || a_size != a_size_reg ||
                 a_source != a_src_reg || a_address != a_addr_reg);
    err_vec[4] = d_set && !d_known;
    err_vec[5] = d_set && d_known && (!exp_ok || d_opcode != {1'b0, exp_dop});
    err_vec[6] = d_set && d_known && (d_size != tbl_size[d_source]);
    err_vec[7] = d_fire && !d_first && (d_opcode != d_op_reg || d_size != d_size_reg ||
                 d_source != d_src_reg);
    err_vec[8] = wd_hit;
    err_vec[9] = a_stall_err | d_stall_err;
    code_src[0] = a_source;
    code_src[1] = a_source;
    code_src[2] = a_source;
    code_src[3] = a_src_reg;
    code_src[4] = d_source;
    code_src[5] = d_source;
    code_src[6] = d_source;
    code_src[7] = d_src_reg;
    code_src[8] = wd_src;
    code_src[9] = a_stall_err ? a_hold_src_reg : d_hold_src_reg;
  end

  // Lowest code wins when several fire together
  logic [3:0]             first_code;
  logic [SOURCE_BITS-1:0] first_src;
  always_comb begin
    first_code = '0;
    first_src  = '0;
    for (int i = 9; i >= 0; i--) begin
      if (err_vec[i]) begin
        first_code = 4'(i + 1);
        first_src  = code_src[i];
      end
    end
  end

  logic [SOURCE_BITS:0] cnt_next;
  always_comb begin
    cnt_next = '0;
    for (int i = 0; i < NSRC; i++) cnt_next = cnt_next + (SOURCE_BITS+1)'(inflight_next[i]);
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      a_cnt_reg       <= '0;
      a_op_reg        <= '0;
      a_size_reg      <= '0;
      a_src_reg       <= '0;
      a_addr_reg      <= '0;
      d_cnt_reg       <= '0;
      d_op_reg        <= '0;
      d_size_reg      <= '0;
      d_src_reg       <= '0;
      a_stall_reg     <= 1'b0;
      a_hold_op_reg   <= '0;
      a_hold_size_reg <= '0;
      a_hold_src_reg  <= '0;
      a_hold_addr_reg <= '0;
      d_stall_reg     <= 1'b0;
      d_hold_op_reg   <= '0;
      d_hold_size_reg <= '0;
      d_hold_src_reg  <= '0;
      wd_reg          <= '0;
      err_valid       <= 1'b0;
      err_code        <= '0;
      err_source      <= '0;
      err_count       <= '0;
      inflight_cnt    <= '0;
    end else begin
      if (a_fire) begin
        a_cnt_reg <= a_last ? '0 : a_cnt_reg + CNT_W'(1);
        if (a_first) begin
          a_op_reg   <= a_opcode;
          a_size_reg <= a_size;
          a_src_reg  <= a_source;
          a_addr_reg <= a_address;
        end
      end
      if (d_fire) begin
        d_cnt_reg <= d_last ? '0 : d_cnt_reg + CNT_W'(1);
        if (d_first) begin
          d_op_reg   <= d_opcode;
          d_size_reg <= d_size;
          d_src_reg  <= d_source;
        end
      end
      a_stall_reg     <= a_valid & ~a_ready;
      a_hold_op_reg   <= a_opcode;
      a_hold_size_reg <= a_size;
      a_hold_src_reg  <= a_source;
      a_hold_addr_reg <= a_address;
      d_stall_reg     <= d_valid & ~d_ready;
      d_hold_op_reg   <= d_opcode;
      d_hold_size_reg <= d_size;
      d_hold_src_reg  <= d_source;
      wd_reg          <= wd_next;
      inflight_cnt    <= cnt_next;
      if (err_vec != '0) begin
        if (err_count != 8'hFF) err_count <= err_count + 8'd1;
        if (!err_valid) begin
          err_valid  <= 1'b1;
          err_code   <= first_code;
          err_source <= first_src;
        end
      end
    end
  end

endmodule

// File: tb/tb_tl_inflight_monitor.sv
// Directed bench for tl_inflight_monitor: hand-computed expectations for tracking,
// burst, stall, watchdog and error-capture behaviour.
module tb_tl_inflight_monitor;
  localparam int SB = 4;
  localparam int AB = 32;
  localparam int ZB = 3;
  localparam int TO = 64;

  logic          clock = 1'b0;
  logic          reset_n = 1'b0;
  logic          a_valid = 1'b0, a_ready = 1'b1;
  logic [2:0]    a_opcode = '0;
  logic [ZB-1:0] a_size = '0;
  logic [SB-1:0] a_source = '0;
  logic [AB-1:0] a_address = '0;
  logic          d_valid = 1'b0, d_ready = 1'b1;
  logic [2:0]    d_opcode = '0;
  logic [ZB-1:0] d_size = '0;
  logic [SB-1:0] d_source = '0;
  logic          err_valid;
  logic [3:0]    err_code;
  logic [SB-1:0] err_source;
  logic [7:0]    err_count;
  logic [SB:0]   inflight_cnt;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clock = ~clock;

  tl_inflight_monitor #(
    .SOURCE_BITS(SB), .ADDR_BITS(AB), .BEAT_BYTES(4), .SIZE_BITS(ZB), .TIMEOUT(TO)
  ) dut (
    .clock(clock), .reset_n(reset_n),
    .a_valid(a_valid), .a_ready(a_ready), .a_opcode(a_opcode), .a_size(a_size),
    .a_source(a_source), .a_address(a_address),
    .d_valid(d_valid), .d_ready(d_ready), .d_opcode(d_opcode), .d_size(d_size),
    .d_source(d_source),
    .err_valid(err_valid), .err_code(err_code), .err_source(err_source),
    .err_count(err_count), .inflight_cnt(inflight_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end else begin
      $display("ok   %s = %0d", tag, got);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic a_beat(input logic [2:0] op, input logic [ZB-1:0] sz,
                        input logic [SB-1:0] src, input logic [AB-1:0] addr);
    a_valid = 1'b1; a_ready = 1'b1;
    a_opcode = op; a_size = sz; a_source = src; a_address = addr;
    tick();
    a_valid = 1'b0;
  endtask

  task automatic d_beat(input logic [2:0] op, input logic [ZB-1:0] sz, input logic [SB-1:0] src);
    d_valid = 1'b1; d_ready = 1'b1;
    d_opcode = op; d_size = sz; d_source = src;
    tick();
    d_valid = 1'b0;
  endtask

  task automatic do_reset();
    reset_n = 1'b0; a_valid = 1'b0; d_valid = 1'b0; a_ready = 1'b1; d_ready = 1'b1;
    tick();
    reset_n = 1'b1;
  endtask

  task automatic chk_err(input string tag, input logic [3:0] code, input logic [SB-1:0] src,
                         input logic [7:0] cnt);
    chk({tag, ".valid"}, 32'(err_valid), 32'(code != 4'd0));
    chk({tag, ".code"},  32'(err_code), 32'(code));
    chk({tag, ".src"},   32'(err_source), 32'(src));
    chk({tag, ".count"}, 32'(err_count), 32'(cnt));
  endtask

  initial begin
    tick();
    do_reset();
    chk_err("reset", 4'd0, 4'd0, 8'd0);
    chk("reset.inflight", 32'(inflight_cnt), 0);

    // Get src3 then AccessAckData three cycles later
    a_beat(3'd4, 3'd2, 4'd3, 32'h100);
    chk("get3.inflight", 32'(inflight_cnt), 1);
    tick(); tick();
    d_beat(3'd1, 3'd2, 4'd3);
    chk("ack3.inflight", 32'(inflight_cnt), 0);

    // Get size4 answered by a 4-beat AccessAckData
    a_beat(3'd4, 3'd4, 4'd4, 32'h80);
    for (int b = 0; b < 3; b++) d_beat(3'd1, 3'd4, 4'd4);
    chk("dburst.mid", 32'(inflight_cnt), 1);
    d_beat(3'd1, 3'd4, 4'd4);
    chk("dburst.end", 32'(inflight_cnt), 0);
    chk("dburst.err", 32'(err_valid), 0);

    // PutFull size4 = 4 beats; the following Get must be a fresh first beat
    for (int b = 0; b < 4; b++) a_beat(3'd0, 3'd4, 4'd1, 32'h40);
    chk("put1.inflight", 32'(inflight_cnt), 1);
    a_beat(3'd4, 3'd2, 4'd2, 32'h44);
    chk("put1.get2", 32'(inflight_cnt), 2);
    d_beat(3'd0, 3'd4, 4'd1);
    chk("put1.ack", 32'(inflight_cnt), 1);
    d_beat(3'd1, 3'd2, 4'd2);
    chk("put1.done", 32'(inflight_cnt), 0);
    chk("put1.err", 32'(err_valid), 0);

    // Same burst with size changed on beat 2
    do_reset();
    a_beat(3'd0, 3'd4, 4'd1, 32'h40);
    a_beat(3'd0, 3'd3, 4'd1, 32'h40);
    a_beat(3'd0, 3'd4, 4'd1, 32'h40);
    a_beat(3'd0, 3'd4, 4'd1, 32'h40);
    chk_err("burstchg", 4'd4, 4'd1, 8'd1);

    // Duplicate Get on src5, then legal same-cycle D-last + A-first
    do_reset();
    a_beat(3'd4, 3'd2, 4'd5, 32'h200);
    a_beat(3'd4, 3'd2, 4'd5, 32'h200);
    chk_err("dup5", 4'd3, 4'd5, 8'd1);
    a_valid = 1'b1; a_opcode = 3'd4; a_size = 3'd2; a_source = 4'd5; a_address = 32'h200;
    d_valid = 1'b1; d_opcode = 3'd1; d_size = 3'd2; d_source = 4'd5;
    tick();
    a_valid = 1'b0; d_valid = 1'b0;
    chk("swap5.count", 32'(err_count), 1);
    chk("swap5.inflight", 32'(inflight_cnt), 1);

    // Wrong D opcode, then a D to a never-requested source
    do_reset();
    a_beat(3'd4, 3'd2, 4'd2, 32'h10);
    d_beat(3'd0, 3'd2, 4'd2);
    chk_err("dop2", 4'd6, 4'd2, 8'd1);
    chk("dop2.inflight", 32'(inflight_cnt), 0);
    d_beat(3'd0, 3'd2, 4'd7);
    chk_err("src7", 4'd6, 4'd2, 8'd2);

    // A valid dropped while stalled
    do_reset();
    a_valid = 1'b1; a_ready = 1'b0;
    a_opcode = 3'd4; a_size = 3'd2; a_source = 4'd6; a_address = 32'h20;
    tick();
    chk("stall.pre", 32'(err_valid), 0);
    a_valid = 1'b0; a_ready = 1'b1;
    tick();
    chk_err("stall", 4'd10, 4'd6, 8'd1);

    // Watchdog on an unanswered Get
    do_reset();
    a_beat(3'd4, 3'd2, 4'd0, 32'h0);
    repeat (TO - 4) tick();
    chk("wd.early", 32'(err_valid), 0);
    repeat (5) tick();
    chk_err("wd", 4'd9, 4'd0, 8'd1);

    // Misaligned address and illegal opcode together: code 1 wins, one count
    do_reset();
    a_beat(3'd7, 3'd2, 4'd9, 32'h1002);
    chk_err("op7", 4'd1, 4'd9, 8'd1);
    chk("op7.inflight", 32'(inflight_cnt), 1);
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    chk_err("rst2", 4'd0, 4'd0, 8'd0);
    chk("rst2.inflight", 32'(inflight_cnt), 0);

    // err_count saturates at 255
    d_valid = 1'b1; d_ready = 1'b1; d_opcode = 3'd0; d_size = 3'd2; d_source = 4'd7;
    repeat (260) tick();
    d_valid = 1'b0;
    chk_err("sat", 4'd5, 4'd7, 8'd255);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
